// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// access-size encodings, FSM state codes and the byte-lane select helper.
package mem_access_ctrl_pkg;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef logic [1:0] mem_size_t;

   // Little-endian lane mask; size 3 behaves as a word.
   function automatic logic [3:0] lane_sel(input mem_size_t size, input logic [1:0] off);
      case (size)
         MEM_SIZE_BYTE: return 4'b0001 << off;
         MEM_SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
         default:       return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_store_align.sv
// mem_store_align: combinational size+address decode into byte-lane mask,
// lane-replicated store data, aligned bus address and misalignment error.
module mem_store_align
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter bit CHECK_EN   = 1'b0
) (
   input  logic [1:0]            size,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata_in,
   output logic [3:0]            sel,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [ADDR_WIDTH-1:0] addr_aligned,
   output logic                  addr_err
);

   logic misaligned;

   always_comb begin
      sel          = lane_sel(size, addr[1:0]);
      wdata        = wdata_in;
      addr_aligned = addr;
      misaligned   = 1'b0;
      case (size)
         MEM_SIZE_BYTE: wdata = {4{wdata_in[7:0]}};
         MEM_SIZE_HALF: begin
            wdata           = {2{wdata_in[15:0]}};
            addr_aligned[0] = 1'b0;
            misaligned      = addr[0];
         end
         default: begin
            addr_aligned[1:0] = 2'b00;
            misaligned        = |addr[1:0];
         end
      endcase
   end

   assign addr_err = CHECK_EN & misaligned;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: load/store to SRAM-like bus with
// stall and registered read data. Optional alignment check: `MEM_ADDR_CHECK_EN.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read_flag_in,
   input  logic                  mem_write_flag_in,
   input  logic [1:0]            mem_size_in,
   input  logic [ADDR_WIDTH-1:0] mem_addr_in,
   input  logic [DATA_WIDTH-1:0] mem_write_data_in,
   input  logic                  stall_current_stage,
   input  logic                  flush,
   output logic                  data_req,
   output logic                  data_wr,
   output logic [1:0]            data_size,
   output logic [ADDR_WIDTH-1:0] data_addr,
   output logic [DATA_WIDTH-1:0] data_wdata,
   input  logic                  data_addr_ok,
   input  logic                  data_data_ok,
   input  logic [DATA_WIDTH-1:0] data_rdata,
   output logic [3:0]            mem_sel_out,
   output logic [DATA_WIDTH-1:0] ram_read_data_out,
   output logic                  stall_request,
   output logic                  addr_err_load,
   output logic                  addr_err_store,
   output logic [ADDR_WIDTH-1:0] bad_vaddr
);

`ifdef MEM_ADDR_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic [1:0]            state;
   logic                  cancel;
   logic [ADDR_WIDTH-1:0] hold_addr;
   logic [DATA_WIDTH-1:0] hold_wdata;
   logic [1:0]            hold_size;
   logic                  hold_wr;
   logic                  hold_load;

   logic [3:0]            sel;
   logic [DATA_WIDTH-1:0] wdata_rep;
   logic [ADDR_WIDTH-1:0] addr_aligned;
   logic                  mis_err;
   logic                  access;
   logic                  addr_err;
   logic                  access_valid;
   logic                  idle_go;

   mem_store_align #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .CHECK_EN   (CHECK_EN)
   ) u_align (
      .size         (mem_size_in),
      .addr         (mem_addr_in),
      .wdata_in     (mem_write_data_in),
      .sel          (sel),
      .wdata        (wdata_rep),
      .addr_aligned (addr_aligned),
      .addr_err     (mis_err)
   );

   assign access       = mem_read_flag_in | mem_write_flag_in;
   assign addr_err     = mis_err & access;
   assign access_valid = access & ~flush & ~addr_err;
   // Gating with rst keeps the request low while reset is held, even in IDLE.
   assign idle_go      = rst & (state == ST_IDLE) & access_valid;

   assign data_req      = idle_go | (state == ST_REQ);
   assign stall_request = idle_go | (state == ST_REQ) | ((state == ST_WAIT) & ~data_data_ok);
   assign mem_sel_out   = access ? sel : 4'b0000;

   assign addr_err_load  = addr_err & ~mem_write_flag_in;
   assign addr_err_store = addr_err & mem_write_flag_in;
`ifdef MEM_ADDR_CHECK_EN
   assign bad_vaddr = mem_addr_in;
`else
   assign bad_vaddr = '0;
`endif

   always_comb begin
      data_wr    = 1'b0;
      data_size  = 2'b00;
      data_addr  = '0;
      data_wdata = '0;
      if (state == ST_REQ) begin
         data_wr    = hold_wr;
         data_size  = hold_size;
         data_addr  = hold_addr;
         data_wdata = hold_wdata;
      end else if (idle_go) begin
         data_wr    = mem_write_flag_in;
         data_size  = mem_size_in;
         data_addr  = addr_aligned;
         data_wdata = wdata_rep;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= ST_IDLE;
         cancel            <= 1'b0;
         hold_addr         <= '0;
         hold_wdata        <= '0;
         hold_size         <= 2'b00;
         hold_wr           <= 1'b0;
         hold_load         <= 1'b0;
         ram_read_data_out <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cancel <= 1'b0;
               if (access_valid) begin
                  hold_addr  <= addr_aligned;
                  hold_wdata <= wdata_rep;
                  hold_size  <= mem_size_in;
                  hold_wr    <= mem_write_flag_in;
                  hold_load  <= ~mem_write_flag_in;
                  state      <= data_addr_ok ? ST_WAIT : ST_REQ;
               end
            end
            ST_REQ: begin
               if (flush) cancel <= 1'b1;
               if (data_addr_ok) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (data_data_ok) begin
                  // A flush arriving in the data_ok cycle itself also discards the data.
                  if (hold_load && !cancel && !flush) ram_read_data_out <= data_rdata;
                  cancel <= 1'b0;
                  state  <= stall_current_stage ? ST_DONE : ST_IDLE;
               end else if (flush) begin
                  cancel <= 1'b1;
               end
            end
            default: begin
               if (!stall_current_stage || flush) state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; bus handshakes driven by hand,
// inputs change 1 ns after the rising edge and outputs are sampled on the falling edge.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        mem_read_flag_in;
   logic        mem_write_flag_in;
   logic [1:0]  mem_size_in;
   logic [31:0] mem_addr_in;
   logic [31:0] mem_write_data_in;
   logic        stall_current_stage;
   logic        flush;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic [3:0]  mem_sel_out;
   logic [31:0] ram_read_data_out;
   logic        stall_request;
   logic        addr_err_load;
   logic        addr_err_store;
   logic [31:0] bad_vaddr;

   int tests_run    = 0;
   int tests_failed = 0;

   mem_access_ctrl #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .mem_read_flag_in    (mem_read_flag_in),
      .mem_write_flag_in   (mem_write_flag_in),
      .mem_size_in         (mem_size_in),
      .mem_addr_in         (mem_addr_in),
      .mem_write_data_in   (mem_write_data_in),
      .stall_current_stage (stall_current_stage),
      .flush               (flush),
      .data_req            (data_req),
      .data_wr             (data_wr),
      .data_size           (data_size),
      .data_addr           (data_addr),
      .data_wdata          (data_wdata),
      .data_addr_ok        (data_addr_ok),
      .data_data_ok        (data_data_ok),
      .data_rdata          (data_rdata),
      .mem_sel_out         (mem_sel_out),
      .ram_read_data_out   (ram_read_data_out),
      .stall_request       (stall_request),
      .addr_err_load       (addr_err_load),
      .addr_err_store      (addr_err_store),
      .bad_vaddr           (bad_vaddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      mem_read_flag_in    = 1'b0;
      mem_write_flag_in   = 1'b0;
      mem_size_in         = 2'd0;
      mem_addr_in         = 32'h0;
      mem_write_data_in   = 32'h0;
      stall_current_stage = 1'b0;
      flush               = 1'b0;
      data_addr_ok        = 1'b0;
      data_data_ok        = 1'b0;
      data_rdata          = 32'h0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      tests_run++;
      if (data_req !== 1'b0 || stall_request !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ctl: req=%b stall=%b, expected 0 0", data_req, stall_request);
      end
      tests_run++;
      if (ram_read_data_out !== 32'h0 || data_addr !== 32'h0 || data_wdata !== 32'h0 || mem_sel_out !== 4'h0) begin
         tests_failed++;
         $display("FAIL reset_data: rdata=%h addr=%h wdata=%h sel=%b, expected all 0",
                  ram_read_data_out, data_addr, data_wdata, mem_sel_out);
      end
      next_cycle();
      rst = 1'b1;
   endtask

   task automatic test_load();
      next_cycle();
      mem_read_flag_in = 1'b1;
      mem_size_in      = 2'd2;
      mem_addr_in      = 32'h8000_0004;
      data_addr_ok     = 1'b1;
      @(negedge clk);
      tests_run++;
      if (data_req !== 1'b1 || data_wr !== 1'b0 || data_addr !== 32'h8000_0004 || stall_request !== 1'b1
          || mem_sel_out !== 4'b1111 || data_size !== 2'd2) begin
         tests_failed++;
         $display("FAIL lw_req: req=%b wr=%b addr=%h stall=%b sel=%b size=%0d, expected 1 0 80000004 1 1111 2",
                  data_req, data_wr, data_addr, stall_request, mem_sel_out, data_size);
      end
      next_cycle();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b1;
      data_rdata   = 32'hDEAD_BEEF;
      @(negedge clk);
      tests_run++;
      if (stall_request !== 1'b0 || data_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL lw_dataok: stall=%b req=%b, expected 0 0", stall_request, data_req);
      end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      tests_run++;
      if (ram_read_data_out !== 32'hDEAD_BEEF) begin
         tests_failed++;
         $display("FAIL lw_rdata: got %h, expected deadbeef", ram_read_data_out);
      end
   endtask

   task automatic test_store_delayed();
      next_cycle();
      mem_write_flag_in = 1'b1;
      mem_size_in       = 2'd0;
      mem_addr_in       = 32'h1000_0003;
      mem_write_data_in = 32'hAABB_CC55;
      for (int i = 0; i < 4; i++) begin
         if (i != 0) next_cycle();
         data_addr_ok = (i == 3);
         @(negedge clk);
         tests_run++;
         if (data_req !== 1'b1 || data_wr !== 1'b1 || data_addr !== 32'h1000_0003
             || data_wdata !== 32'h5555_5555 || mem_sel_out !== 4'b1000 || stall_request !== 1'b1
             || data_size !== 2'd0) begin
            tests_failed++;
            $display("FAIL sb_hold[%0d]: req=%b wr=%b addr=%h wdata=%h sel=%b stall=%b size=%0d, expected 1 1 10000003 55555555 1000 1 0",
                     i, data_req, data_wr, data_addr, data_wdata, mem_sel_out, stall_request, data_size);
         end
      end
      next_cycle();
      data_addr_ok = 1'b0;
      @(negedge clk);
      tests_run++;
      if (stall_request !== 1'b1 || data_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL sb_wait: stall=%b req=%b, expected 1 0", stall_request, data_req);
      end
      next_cycle();
      data_data_ok = 1'b1;
      data_rdata   = 32'h0BAD_F00D;
      @(negedge clk);
      tests_run++;
      if (stall_request !== 1'b0) begin
         tests_failed++;
         $display("FAIL sb_dataok: stall=%b, expected 0", stall_request);
      end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      tests_run++;
      if (ram_read_data_out !== 32'hDEAD_BEEF || data_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL sb_nordata: rdata=%h req=%b, expected deadbeef 0", ram_read_data_out, data_req);
      end
   endtask

   task automatic test_stall_hold();
      next_cycle();
      mem_read_flag_in = 1'b1;
      mem_size_in      = 2'd2;
      mem_addr_in      = 32'h8000_0008;
      data_addr_ok     = 1'b1;
      next_cycle();
      data_addr_ok        = 1'b0;
      data_data_ok        = 1'b1;
      data_rdata          = 32'h1234_5678;
      stall_current_stage = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         data_data_ok        = 1'b0;
         data_rdata          = 32'hFFFF_0000 + i;
         stall_current_stage = (i < 2);
         @(negedge clk);
         tests_run++;
         if (data_req !== 1'b0 || stall_request !== 1'b0 || ram_read_data_out !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL done_hold[%0d]: req=%b stall=%b rdata=%h, expected 0 0 12345678",
                     i, data_req, stall_request, ram_read_data_out);
         end
      end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      tests_run++;
      if (ram_read_data_out !== 32'h1234_5678 || data_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL done_exit: rdata=%h req=%b, expected 12345678 0", ram_read_data_out, data_req);
      end
   endtask

   task automatic test_flush_wait();
      next_cycle();
      mem_read_flag_in = 1'b1;
      mem_size_in      = 2'd2;
      mem_addr_in      = 32'h8000_0010;
      data_addr_ok     = 1'b1;
      next_cycle();
      data_addr_ok = 1'b0;
      flush        = 1'b1;
      @(negedge clk);
      tests_run++;
      if (stall_request !== 1'b1 || data_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_wait: stall=%b req=%b, expected 1 0", stall_request, data_req);
      end
      next_cycle();
      flush            = 1'b0;
      mem_read_flag_in = 1'b0;
      @(negedge clk);
      tests_run++;
      if (stall_request !== 1'b1 || data_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_hold: stall=%b req=%b, expected 1 0", stall_request, data_req);
      end
      next_cycle();
      data_data_ok = 1'b1;
      data_rdata   = 32'hBAD0_BAD0;
      @(negedge clk);
      tests_run++;
      if (stall_request !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_dataok: stall=%b, expected 0", stall_request);
      end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      tests_run++;
      if (ram_read_data_out !== 32'h1234_5678 || data_req !== 1'b0 || stall_request !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_discard: rdata=%h req=%b stall=%b, expected 12345678 0 0",
                  ram_read_data_out, data_req, stall_request);
      end
   endtask

   task automatic test_lanes();
      logic [1:0]  v_size  [4] = '{2'd0, 2'd1, 2'd1, 2'd3};
      logic [31:0] v_addr  [4] = '{32'h4000_0001, 32'h4000_0002, 32'h4000_0000, 32'h4000_0008};
      logic [31:0] v_data  [4] = '{32'h0000_00A5, 32'h1234_BEEF, 32'h0000_BEEF, 32'hCAFE_F00D};
      logic [3:0]  e_sel   [4] = '{4'b0010, 4'b1100, 4'b0011, 4'b1111};
      logic [31:0] e_wdata [4] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'hBEEF_BEEF, 32'hCAFE_F00D};
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         mem_write_flag_in = 1'b1;
         mem_size_in       = v_size[i];
         mem_addr_in       = v_addr[i];
         mem_write_data_in = v_data[i];
         data_addr_ok      = 1'b1;
         @(negedge clk);
         tests_run++;
         if (mem_sel_out !== e_sel[i] || data_wdata !== e_wdata[i] || data_addr !== v_addr[i]
             || data_req !== 1'b1 || data_wr !== 1'b1 || data_size !== v_size[i]) begin
            tests_failed++;
            $display("FAIL lanes[%0d]: sel=%b wdata=%h addr=%h req=%b wr=%b size=%0d, expected %b %h %h 1 1 %0d",
                     i, mem_sel_out, data_wdata, data_addr, data_req, data_wr, data_size,
                     e_sel[i], e_wdata[i], v_addr[i], v_size[i]);
         end
         next_cycle();
         idle_inputs();
         data_data_ok = 1'b1;
      end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_unaligned();
      next_cycle();
      mem_read_flag_in = 1'b1;
      mem_size_in      = 2'd1;
      mem_addr_in      = 32'h8000_0021;
      data_addr_ok     = 1'b1;
      @(negedge clk);
`ifdef MEM_ADDR_CHECK_EN
      tests_run++;
      if (addr_err_load !== 1'b1 || addr_err_store !== 1'b0 || bad_vaddr !== 32'h8000_0021
          || data_req !== 1'b0 || stall_request !== 1'b0) begin
         tests_failed++;
         $display("FAIL lh_err: err_ld=%b err_st=%b bad=%h req=%b stall=%b, expected 1 0 80000021 0 0",
                  addr_err_load, addr_err_store, bad_vaddr, data_req, stall_request);
      end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      tests_run++;
      if (ram_read_data_out !== 32'h1234_5678 || stall_request !== 1'b0) begin
         tests_failed++;
         $display("FAIL lh_err_idle: rdata=%h stall=%b, expected 12345678 0", ram_read_data_out, stall_request);
      end
`else
      tests_run++;
      if (data_addr !== 32'h8000_0020 || mem_sel_out !== 4'b0011 || data_req !== 1'b1
          || addr_err_load !== 1'b0 || addr_err_store !== 1'b0 || bad_vaddr !== 32'h0) begin
         tests_failed++;
         $display("FAIL lh_align: addr=%h sel=%b req=%b err_ld=%b err_st=%b bad=%h, expected 80000020 0011 1 0 0 0",
                  data_addr, mem_sel_out, data_req, addr_err_load, addr_err_store, bad_vaddr);
      end
      next_cycle();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b1;
      data_rdata   = 32'h0000_CAFE;
      next_cycle();
      idle_inputs();
      @(negedge clk);
      tests_run++;
      if (ram_read_data_out !== 32'h0000_CAFE) begin
         tests_failed++;
         $display("FAIL lh_rdata: got %h, expected 0000cafe", ram_read_data_out);
      end
`endif
   endtask

   task automatic test_reset_mid();
      next_cycle();
      mem_read_flag_in = 1'b1;
      mem_size_in      = 2'd2;
      mem_addr_in      = 32'h8000_0030;
      data_addr_ok     = 1'b1;
      next_cycle();
      data_addr_ok = 1'b0;
      #2;
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (data_req !== 1'b0 || stall_request !== 1'b0 || ram_read_data_out !== 32'h0) begin
         tests_failed++;
         $display("FAIL rst_mid: req=%b stall=%b rdata=%h, expected 0 0 0",
                  data_req, stall_request, ram_read_data_out);
      end
      next_cycle();
      idle_inputs();
      rst = 1'b1;
      // A stray data_ok must be ignored once the FSM is back in IDLE.
      data_data_ok = 1'b1;
      data_rdata   = 32'h7777_7777;
      @(negedge clk);
      tests_run++;
      if (stall_request !== 1'b0 || data_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_idle: stall=%b req=%b, expected 0 0", stall_request, data_req);
      end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      tests_run++;
      if (ram_read_data_out !== 32'h0) begin
         tests_failed++;
         $display("FAIL rst_nolatch: rdata=%h, expected 0", ram_read_data_out);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store_delayed();
      test_stall_hold();
      test_flush_wait();
      test_lanes();
      test_unaligned();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
